// File: rtl/dbpsk_pkg.sv
// Shared definitions for the DBPSK receive path and the modulator-side framer.
package dbpsk_pkg;

  // Receiver frame state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int          DEFAULT_OVERSAMPLE  = 8;
  localparam logic [15:0] DEFAULT_SYNC_WORD   = 16'hD391;
  localparam int          DEFAULT_FRAME_BYTES = 4;

endpackage

// File: rtl/dbpsk_demodulator_if.sv
// Output bundle of the DBPSK demodulator: decoded byte stream plus status.
//
// Handshake: valid-only, no back-pressure. output_data is meaningful in the
// single cycle output_valid is high and holds its value afterwards. The sink
// must accept every pulse; sync_found and frame_done are one-cycle events,
// frame_done always coincides with the last byte's output_valid.
interface dbpsk_demodulator_if;
  import dbpsk_pkg::*;

  logic [7:0] output_data;
  logic       output_valid;
  logic       sync_found;
  logic       frame_done;
  logic       busy;
  state_t     dbg_state;

  modport master (
    output output_data, output_valid, sync_found, frame_done, busy, dbg_state
  );

  modport slave (
    input output_data, output_valid, sync_found, frame_done, busy, dbg_state
  );

endinterface

// File: rtl/dbpsk_symbol_timing.sv
// Edge-locked symbol timing recovery: samples each symbol half a symbol after
// the most recent line transition, free-running between transitions.
module dbpsk_symbol_timing #(
  parameter int OVERSAMPLE = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_en,
  input  logic input_dbpsk,
  output logic sym_strobe,
  output logic sym_value
);

  localparam int             PW           = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0]  STROBE_PHASE = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0]  PHASE_LAST   = PW'(OVERSAMPLE - 1);

  logic          last_sample_q;
  logic [PW-1:0] phase_q;
  logic          edge_det;

  assign edge_det   = input_dbpsk ^ last_sample_q;
  // A transition in the strobe slot means the symbol is not yet stable.
  assign sym_strobe = sample_en & ~edge_det & (phase_q == STROBE_PHASE);
  assign sym_value  = input_dbpsk;

  // Track the previous sample and realign the phase counter on every edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_sample_q <= 1'b0;
      phase_q       <= '0;
    end else if (sample_en) begin
      last_sample_q <= input_dbpsk;
      if (edge_det || phase_q == PHASE_LAST) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbpsk_demodulator.sv
// DBPSK receiver: symbol timing, differential decode, sync hunt and
// fixed-length byte framing.
module dbpsk_demodulator
  import dbpsk_pkg::*;
#(
  parameter int          OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter logic [15:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter int          FRAME_BYTES = DEFAULT_FRAME_BYTES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_en,
  input  logic                input_dbpsk,
  dbpsk_demodulator_if.master out_if
);

  localparam int            IW        = $clog2(OVERSAMPLE);
  localparam logic [IW-1:0] IDLE_LAST = IW'(OVERSAMPLE - 1);
  localparam logic [7:0]    LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          prev_sym_q, prev_sym_d;
  logic [15:0]   sreg_q, sreg_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          sync_q, sync_d;
  logic          done_q, done_d;

  logic          sym_strobe;
  logic          sym_value;
  logic          dec_bit;
  logic [15:0]   sreg_shift;
  logic [7:0]    byte_shift;

  dbpsk_symbol_timing #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .sample_en   (sample_en),
    .input_dbpsk (input_dbpsk),
    .sym_strobe  (sym_strobe),
    .sym_value   (sym_value)
  );

  assign dec_bit    = sym_value ^ prev_sym_q;
  assign sreg_shift = {sreg_q[14:0], dec_bit};
  assign byte_shift = {byte_q[6:0], dec_bit};

  // Next-state and datapath updates; pulses default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    prev_sym_d = prev_sym_q;
    sreg_d     = sreg_q;
    byte_d     = byte_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sync_d     = 1'b0;
    done_d     = 1'b0;
    if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          if (input_dbpsk) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_d = '0;
            prev_sym_d = 1'b0;
            sreg_d     = '0;
            state_d    = ST_HUNT;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        ST_HUNT: begin
          if (sym_strobe) begin
            prev_sym_d = sym_value;
            sreg_d     = sreg_shift;
            if (sreg_shift == SYNC_WORD) begin
              sync_d     = 1'b1;
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
              state_d    = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sym_strobe) begin
            prev_sym_d = sym_value;
            byte_d     = byte_shift;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              data_d     = byte_shift;
              valid_d    = 1'b1;
              bit_cnt_d  = '0;
              byte_cnt_d = byte_cnt_q + 1'b1;
              if (byte_cnt_q == LAST_BYTE) begin
                done_d     = 1'b1;
                idle_cnt_d = '0;
                state_d    = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
      prev_sym_q <= 1'b0;
      sreg_q     <= '0;
      byte_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      prev_sym_q <= prev_sym_d;
      sreg_q     <= sreg_d;
      byte_q     <= byte_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sync_q     <= sync_d;
      done_q     <= done_d;
    end
  end

  assign out_if.output_data  = data_q;
  assign out_if.output_valid = valid_q;
  assign out_if.sync_found   = sync_q;
  assign out_if.frame_done   = done_q;
  assign out_if.busy         = (state_q != ST_IDLE);
  assign out_if.dbg_state    = state_q;

endmodule

// File: tb/tb_dbpsk_demodulator.sv
// Bench for dbpsk_demodulator: differential line encoding with optional edge
// jitter, a bit-level frame model feeding an expected-byte queue, and checks
// on pulse widths, byte values, sync/frame counts and busy.
module tb_dbpsk_demodulator;
  import dbpsk_pkg::*;

  localparam int          OS   = 8;
  localparam int          FB   = 4;
  localparam logic [15:0] SYNC = 16'hD391;

  // ---------------- clock / reset ----------------
  logic clock       = 1'b0;
  logic reset       = 1'b0;
  logic sample_en   = 1'b0;
  logic input_dbpsk = 1'b0;

  always #5 clock = ~clock;

  dbpsk_demodulator_if out_if ();

  dbpsk_demodulator #(
    .OVERSAMPLE  (OS),
    .SYNC_WORD   (SYNC),
    .FRAME_BYTES (FB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_en   (sample_en),
    .input_dbpsk (input_dbpsk),
    .out_if      (out_if)
  );

  // ---------------- bookkeeping ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [8:0] exp_q[$];          // {last_of_frame, byte}
  logic       tx_bits[$];        // decoded-bit content of the next burst
  int         gap = 1;           // clock cycles between sample_en strobes
  int         exp_sync = 0;
  int         exp_frames = 0;
  int         seen_sync = 0;
  int         seen_frames = 0;
  logic [7:0] exp_data = 8'h00;
  bit         model_done;
  logic       prev_valid = 1'b0;
  logic       prev_sync  = 1'b0;
  logic       prev_done  = 1'b0;
  logic [8:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Scan the burst's decoded bits for the sync word, then cut the following
  // bits into MSB-first bytes until the frame is complete or bits run out.
  task automatic model_burst();
    logic [15:0] win;
    logic [7:0]  b;
    int          i;
    int          nb;
    bit          locked;
    win = '0; b = '0; i = 0; nb = 0; locked = 0;
    while (i < tx_bits.size() && !locked) begin
      win = {win[14:0], tx_bits[i]};
      i++;
      if (win == SYNC) begin
        locked = 1;
        exp_sync++;
      end
    end
    if (locked) begin
      while (nb < FB && i + 8 <= tx_bits.size()) begin
        for (int k = 0; k < 8; k++) b = {b[6:0], tx_bits[i + k]};
        i += 8;
        nb++;
        exp_q.push_back({(nb == FB), b});
        exp_data = b;
      end
    end
    model_done = (nb == FB);
    if (model_done) exp_frames++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic v);
    @(negedge clock);
    input_dbpsk = v;
    sample_en   = 1'b1;
    for (int i = 1; i < gap; i++) begin
      @(negedge clock);
      sample_en = 1'b0;
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sample_en = 1'b0;
    end
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_sample(1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) tx_bits.push_back(w[i]);
  endtask

  // Differentially encode tx_bits from level 0. With jitter, each transition
  // moves by -2..+2 samples, limited so no run shrinks by 4 samples or more.
  task automatic send_burst(input bit jitter);
    int   n, j_cur, j_next, j_edge, lo, len;
    logic lvl;
    n = tx_bits.size(); lvl = 1'b0; j_cur = 0; j_edge = 0;
    for (int k = 0; k < n; k++) begin
      lvl    = lvl ^ tx_bits[k];
      j_next = 0;
      if (jitter && k + 1 < n && tx_bits[k + 1]) begin
        lo     = (j_edge - 3 > -2) ? j_edge - 3 : -2;
        j_next = lo + int'($urandom_range(0, 2 - lo));
        j_edge = j_next;
      end
      len = OS + j_next - j_cur;
      for (int s = 0; s < len; s++) send_sample(lvl);
      j_cur = j_next;
    end
  endtask

  task automatic frame_bits(input logic [15:0] w, input logic [31:0] payload);
    tx_bits.delete();
    push_word(w);
    for (int i = 3; i >= 0; i--) push_byte(payload[i*8 +: 8]);
  endtask

  task automatic end_checks(input string tag);
    quiet(3);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    check({tag, "_sync_count"}, seen_sync, exp_sync);
    check({tag, "_frame_count"}, seen_frames, exp_frames);
    check({tag, "_data_hold"}, out_if.output_data, exp_data);
    check({tag, "_busy"}, out_if.busy, !model_done);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (out_if.output_valid) begin
        check("valid_width", prev_valid, 0);
        check("valid_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("byte_data", out_if.output_data, mon_e[7:0]);
          check("done_on_last_byte", out_if.frame_done, mon_e[8]);
        end
      end
      if (out_if.frame_done) begin
        check("done_needs_valid", out_if.output_valid, 1);
        check("busy_low_at_done", out_if.busy, 0);
        check("done_width", prev_done, 0);
        seen_frames++;
      end
      if (out_if.sync_found) begin
        check("sync_width", prev_sync, 0);
        seen_sync++;
      end
    end
    prev_valid = out_if.output_valid;
    prev_sync  = out_if.sync_found;
    prev_done  = out_if.frame_done;
  end

  // ---------------- directed sequence ----------------
  initial begin
    // 1: reset values with random line activity, then idle detection
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      input_dbpsk = 1'($urandom_range(0, 1));
      sample_en   = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    check("rst_data", out_if.output_data, 0);
    check("rst_valid", out_if.output_valid, 0);
    check("rst_sync", out_if.sync_found, 0);
    check("rst_done", out_if.frame_done, 0);
    check("rst_busy", out_if.busy, 0);
    check("rst_state", 32'(out_if.dbg_state), 32'(ST_IDLE));
    reset = 1'b1; input_dbpsk = 1'b0; sample_en = 1'b0;
    send_zeros(7);
    quiet(1);
    check("idle_7_zeros_busy", out_if.busy, 0);
    send_sample(1'b0);
    quiet(1);
    check("idle_8_zeros_busy", out_if.busy, 1);
    check("idle_8_zeros_state", 32'(out_if.dbg_state), 32'(ST_HUNT));

    // 2: clean frame, sample_en every cycle
    gap = 1;
    frame_bits(SYNC, 32'hA500FF3C);
    model_burst();
    send_zeros(8);
    send_burst(1'b0);
    end_checks("clean");

    // 3: same frame with jittered edges, twice
    for (int r = 0; r < 2; r++) begin
      frame_bits(SYNC, 32'hA500FF3C);
      model_burst();
      send_zeros(16);
      send_burst(1'b1);
      end_checks("jitter");
    end

    // 4: one sync bit wrong, payload, then the correct sync and a frame
    tx_bits.delete();
    push_word(SYNC ^ 16'h0001);
    for (int i = 3; i >= 0; i--) push_byte(8'(32'hA500FF3C >> (i * 8)));
    push_word(SYNC);
    for (int i = 3; i >= 0; i--) push_byte(8'(32'h1234C0DE >> (i * 8)));
    model_burst();
    send_zeros(16);
    send_burst(1'b0);
    end_checks("false_sync");

    // 5: reset after 12 payload bits, then a full frame
    tx_bits.delete();
    push_word(SYNC);
    push_byte(8'h5A);
    for (int i = 0; i < 4; i++) tx_bits.push_back(1'b1);
    model_burst();
    send_zeros(16);
    send_burst(1'b0);
    end_checks("partial");
    @(negedge clock);
    reset = 1'b0; input_dbpsk = 1'b0;
    quiet(3);
    check("midrst_busy", out_if.busy, 0);
    check("midrst_data", out_if.output_data, 0);
    exp_data = 8'h00;
    reset = 1'b1;
    quiet(8);
    check("midrst_no_stray_byte", exp_q.size(), 0);
    frame_bits(SYNC, 32'hC3E1_7700);
    model_burst();
    send_zeros(16);
    send_burst(1'b0);
    end_checks("after_reset");

    // 6: sample_en every 3rd cycle
    gap = 3;
    frame_bits(SYNC, 32'hA500FF3C);
    model_burst();
    send_zeros(16);
    send_burst(1'b0);
    end_checks("sparse");

    // 7: random payloads, random strobe spacing, jitter
    for (int r = 0; r < 3; r++) begin
      gap = int'($urandom_range(1, 4));
      frame_bits(SYNC, $urandom());
      model_burst();
      send_zeros(16);
      send_burst(1'b1);
      end_checks("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
